// File: rtl/xor_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : xor_key_sequencer
// Purpose  : Upstream feeder for the XOR encryption stage. Buffers plaintext
//            bytes in a small FIFO and presents each byte together with the
//            active key and a per-byte rotation amount. The rotation steps
//            once per byte within a frame and restarts at 0 on every frame.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            key_load, key_in      - key update request and new key value
//            in_valid/in_ready     - upstream byte handshake
//            in_data, in_last      - plaintext byte, end-of-frame marker
//            out_valid/out_ready   - downstream byte handshake
//            out_din, out_key      - byte and key for the encrypter
//            out_shift, out_last   - rotation amount, end-of-frame marker
//            key_busy              - key_load is currently ignored
// Revision : 1.0 - initial release
// ============================================================================
module xor_key_sequencer #(
  parameter int DEPTH   = 4,
  parameter int SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_load,
  input  logic [7:0]         key_in,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_din,
  output logic [7:0]         out_key,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_last,
  output logic               key_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MID  = 1'b1
  } state_t;

  logic [DEPTH-1:0][7:0] data_q, data_d;
  logic [DEPTH-1:0]      last_q, last_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  state_t                state_q, state_d;
  logic [7:0]            key_q, key_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;

  logic push;
  logic pop;

  // in_ready looks only at the occupancy: a full FIFO refuses a byte even if
  // the head is being consumed in the same cycle.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head fields are forced to zero when the FIFO is empty so stale storage
  // never leaks onto the outputs.
  assign out_din   = out_valid ? data_q[rd_ptr_q] : 8'h00;
  assign out_last  = out_valid ? last_q[rd_ptr_q] : 1'b0;
  assign out_key   = key_q;
  assign out_shift = shift_q;

  // The key may change only between frames with nothing left in the FIFO,
  // which keeps it constant for every byte of a frame.
  assign key_busy  = (state_q == ST_MID) | out_valid;

  always_comb begin
    data_d   = data_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    key_d    = key_q;
    shift_d  = shift_q;

    if (push) begin
      data_d[wr_ptr_q] = in_data;
      last_d[wr_ptr_q] = in_last;
      wr_ptr_d         = wr_ptr_q + AW'(1);
      // Every push either closes the frame or leaves one open.
      state_d          = in_last ? ST_IDLE : ST_MID;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      // Natural overflow of the SHIFT_W-bit counter gives the wrap to 0.
      shift_d  = out_last ? '0 : shift_q + SHIFT_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A request made while busy is simply dropped.
    if (key_load && !key_busy) begin
      key_d = key_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      key_q    <= 8'h00;
      shift_q  <= '0;
    end else begin
      data_q   <= data_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      key_q    <= key_d;
      shift_q  <= shift_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xor_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_key_sequencer
// Purpose  : Directed self-checking bench for xor_key_sequencer. Inputs are
//            driven 1 ns after the rising edge; outputs are sampled at the
//            same point, well away from the next active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xor_key_sequencer;

  logic       clk;
  logic       rst;
  logic       key_load;
  logic [7:0] key_in;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_din;
  logic [7:0] out_key;
  logic [2:0] out_shift;
  logic       out_last;
  logic       key_busy;

  int n_cmp;
  int n_err;

  xor_key_sequencer #(
    .DEPTH   (4),
    .SHIFT_W (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_din   (out_din),
    .out_key   (out_key),
    .out_shift (out_shift),
    .out_last  (out_last),
    .key_busy  (key_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t3_bytes [4];
    int         nxt;
    logic       pushed;

    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    key_load  = 1'b0;
    key_in    = 8'h00;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_din",   32'(out_din),   32'h00);
    check("rst_out_shift", 32'(out_shift), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_key_busy",  32'(key_busy),  32'd0);
    check("rst_out_key",   32'(out_key),   32'h00);

    // ---------------- 1: key load + 3-byte frame ----------------
    key_load  = 1'b1;
    key_in    = 8'hA8;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    key_load = 1'b0;
    check("t1_key",    32'(out_key),   32'hA8);
    check("t1_din0",   32'(out_din),   32'hFF);
    check("t1_shift0", 32'(out_shift), 32'd0);
    check("t1_last0",  32'(out_last),  32'd0);
    tick();
    check("t1_shift1", 32'(out_shift), 32'd1);
    check("t1_last1",  32'(out_last),  32'd0);
    in_last = 1'b1;
    tick();
    check("t1_shift2", 32'(out_shift), 32'd2);
    check("t1_last2",  32'(out_last),  32'd1);
    check("t1_din2",   32'(out_din),   32'hFF);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    check("t1_empty",      32'(out_valid), 32'd0);
    check("t1_shift_rst",  32'(out_shift), 32'd0);
    check("t1_busy_after", 32'(key_busy),  32'd0);

    // ---------------- 2: 10-byte frame, shift wraps ----------------
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      in_last  = (i == 9);
      tick();
      check($sformatf("t2_din%0d", i),   32'(out_din),   32'(i));
      check($sformatf("t2_shift%0d", i), 32'(out_shift), 32'(i % 8));
      check($sformatf("t2_last%0d", i),  32'(out_last),  (i == 9) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    check("t2_empty", 32'(out_valid), 32'd0);
    check("t2_shift", 32'(out_shift), 32'd0);

    // ---------------- 3: fill, back-pressure, drain ----------------
    t3_bytes[0] = 8'h11;
    t3_bytes[1] = 8'h22;
    t3_bytes[2] = 8'h33;
    t3_bytes[3] = 8'h44;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = t3_bytes[i];
      in_last  = (i == 3);
      tick();
      check($sformatf("t3_hold%0d", i),  32'(out_din),  32'h11);
      check($sformatf("t3_ready%0d", i), 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    in_data = 8'h55;
    in_last = 1'b0;
    tick();
    tick();
    check("t3_full_ready", 32'(in_ready),  32'd0);
    check("t3_full_din",   32'(out_din),   32'h11);
    check("t3_full_shift", 32'(out_shift), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("t3_drain_din%0d", i),   32'(out_din),   32'(t3_bytes[i]));
      check($sformatf("t3_drain_shift%0d", i), 32'(out_shift), 32'(i));
    end
    check("t3_drain_last", 32'(out_last), 32'd1);
    tick();
    check("t3_no_fifth", 32'(out_valid), 32'd0);
    check("t3_shift0",   32'(out_shift), 32'd0);

    // ---------------- 4: key load ignored mid-frame ----------------
    in_valid = 1'b1;
    in_data  = 8'h66;
    in_last  = 1'b0;
    tick();
    in_valid = 1'b0;
    key_load = 1'b1;
    key_in   = 8'h5C;
    check("t4_busy_cnt", 32'(key_busy), 32'd1);
    tick();
    check("t4_key_drop1", 32'(out_key),   32'hA8);
    check("t4_busy_mid",  32'(key_busy),  32'd1);
    check("t4_empty_mid", 32'(out_valid), 32'd0);
    tick();
    check("t4_key_drop2", 32'(out_key), 32'hA8);
    key_load = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t4_din77",   32'(out_din),   32'h77);
    check("t4_shift77", 32'(out_shift), 32'd1);
    tick();
    check("t4_idle_busy", 32'(key_busy), 32'd0);
    check("t4_not_queued", 32'(out_key), 32'hA8);
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check("t4_key_new", 32'(out_key), 32'h5C);

    // ---------------- 5: reset mid-operation ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hB0 + i);
      in_last  = 1'b0;
      tick();
    end
    out_ready = 1'b0;
    for (int i = 3; i < 5; i++) begin
      in_data = 8'(8'hB0 + i);
      tick();
    end
    in_valid = 1'b0;
    check("t5_pre_shift", 32'(out_shift), 32'd2);
    check("t5_pre_din",   32'(out_din),   32'hB2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_ready", 32'(in_ready),  32'd1);
    check("t5_shift", 32'(out_shift), 32'd0);
    check("t5_key",   32'(out_key),   32'h00);
    check("t5_din",   32'(out_din),   32'h00);
    check("t5_busy",  32'(key_busy),  32'd0);

    // ---------------- 6: full FIFO, sustained throughput ----------------
    out_ready = 1'b0;
    in_last   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hC0 + k);
      tick();
    end
    check("t6_full", 32'(in_ready), 32'd0);
    nxt       = 4;
    out_ready = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      in_valid = (t <= 8);
      in_data  = 8'(8'hC0 + nxt);
      pushed   = in_valid && in_ready;
      tick();
      if (pushed) nxt = nxt + 1;
      check($sformatf("t6_valid%0d", t), 32'(out_valid), 32'd1);
      check($sformatf("t6_din%0d", t),   32'(out_din),   32'(8'hC0 + t));
    end
    in_valid = 1'b0;
    tick();
    check("t6_drained", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
